// File: rtl/mvm_sequencer.sv
// Control sequencer for the matrix-vector multiply datapath: clear, fetch, compute,
// snapshot the MAC lanes and stream them out over a valid/ready port.
module mvm_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_MACS       = 8,
    parameter int unsigned ACC_WIDTH      = 3 * DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SEL_W          = $clog2(NUM_MACS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          cont_mode,
    output logic                          mem_start,
    input  logic                          mem_done,
    output logic                          clr_accum,
    output logic                          start_compute,
    input  logic                          compute_done,
    input  logic [NUM_MACS*ACC_WIDTH-1:0] mac_out_flat,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_WIDTH-1:0]          res_data,
    output logic [SEL_W-1:0]              res_idx,
    output logic                          res_last,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [2:0]                    state_out,
    output logic [15:0]                   pass_count
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StFetch   = 3'd2,
        StCompute = 3'd3,
        StCapture = 3'd4,
        StDrain   = 3'd5,
        StDone    = 3'd6,
        StError   = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [15:0]          pass_q, pass_d;
    logic                 terr_q, terr_d;
    logic [ACC_WIDTH-1:0] shadow_q [NUM_MACS];

    logic wdog_expired;
    logic xfer;
    logic idx_last;
    logic capture_en;

    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign xfer         = (state_q == StDrain) && res_ready;
    assign idx_last     = (idx_q == SEL_W'(NUM_MACS - 1));
    assign capture_en   = (state_q == StCapture) && !abort;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StClear;
            StClear:   state_d = StFetch;
            // Done input beats a simultaneous watchdog expiry.
            StFetch: begin
                if (mem_done)          state_d = StCompute;
                else if (wdog_expired) state_d = StError;
            end
            StCompute: begin
                if (compute_done)      state_d = StCapture;
                else if (wdog_expired) state_d = StError;
            end
            StCapture: state_d = StDrain;
            StDrain:   if (xfer && idx_last) state_d = cont_mode ? StClear : StDone;
            StDone:    if (!start) state_d = StIdle;
            StError:   state_d = StError;
        endcase
        if (abort) state_d = StIdle;
    end

    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q == StFetch || state_q == StCompute) begin
            wdog_d = wdog_q + 1'b1;
        end

        idx_d = idx_q;
        if (capture_en) begin
            idx_d = '0;
        end else if (xfer && !abort) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end

        pass_d = capture_en ? pass_q + 16'd1 : pass_q;

        terr_d = terr_q;
        if (abort) begin
            terr_d = 1'b0;
        end else if (state_d == StError) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wdog_q  <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            terr_q  <= terr_d;
        end
    end

    // Snapshot is retained after the drain until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MACS; i++) shadow_q[i] <= '0;
        end else if (capture_en) begin
            for (int i = 0; i < NUM_MACS; i++) begin
                shadow_q[i] <= mac_out_flat[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign mem_start     = (state_q == StFetch);
    assign clr_accum     = (state_q == StClear);
    assign start_compute = (state_q == StCompute);
    assign res_valid     = (state_q == StDrain);
    assign res_data      = shadow_q[idx_q];
    assign res_idx       = idx_q;
    assign res_last      = (state_q == StDrain) && idx_last;
    assign busy          = (state_q != StIdle) && (state_q != StDone);
    assign timeout_err   = terr_q;
    assign state_out     = state_q;
    assign pass_count    = pass_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Scoreboard bench for mvm_sequencer: directed passes, backpressure, continuous
// mode, watchdog timeout, abort and mid-pass reset.
module tb_mvm_sequencer;

    localparam int NM = 8;
    localparam int AW = 24;
    localparam int TO = 16;
    localparam int SW = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, cont_mode = 1'b0;
    logic mem_done = 1'b0, compute_done = 1'b0;
    logic [NM*AW-1:0] mac_out_flat = '0;
    logic ready_base = 1'b0, bp_en = 1'b0, bp_bit = 1'b0;
    logic res_ready;
    logic mem_start, clr_accum, start_compute, res_valid, res_last, busy, timeout_err;
    logic [AW-1:0] res_data;
    logic [SW-1:0] res_idx;
    logic [2:0]    state_out;
    logic [15:0]   pass_count;

    assign res_ready = bp_en ? bp_bit : ready_base;

    mvm_sequencer #(
        .DATA_WIDTH    (8),
        .NUM_MACS      (NM),
        .ACC_WIDTH     (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cont_mode    (cont_mode),
        .mem_start    (mem_start),
        .mem_done     (mem_done),
        .clr_accum    (clr_accum),
        .start_compute(start_compute),
        .compute_done (compute_done),
        .mac_out_flat (mac_out_flat),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .res_last     (res_last),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .state_out    (state_out),
        .pass_count   (pass_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;
    int clr_count = 0;

    typedef struct packed {
        logic [AW-1:0] data;
        logic [SW-1:0] idx;
        logic          last;
    } word_t;

    word_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold during stalls.
    logic  prev_stall = 1'b0;
    word_t prev_w;
    always @(negedge clk) begin
        word_t cur;
        word_t w;
        cur = {res_data, res_idx, res_last};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (clr_accum) clr_count++;
            if (res_valid && prev_stall) check("stall_hold", cur, prev_w);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no transfer", cur);
                end else begin
                    w = exp_q.pop_front();
                    check("word", cur, w);
                    n_words++;
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_w     = cur;
        end
    end

    // 1,0,0,1 ready pattern for the backpressure test.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            bp_bit = (k % 4 == 0) || (k % 4 == 3);
            k++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_out !== s && n < budget) begin
            step();
            n++;
        end
        check(name, state_out, s);
    endtask

    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
        mem_done = 1'b0; compute_done = 1'b0;
        ready_base = 1'b0; bp_en = 1'b0;
        exp_q.delete();
        #12;
        rst_n = 1'b1;
        step();
        clr_count = 0;
        n_words = 0;
    endtask

    task automatic set_lanes(input logic [AW-1:0] base, input logic [AW-1:0] stride);
        for (int i = 0; i < NM; i++) mac_out_flat[i*AW +: AW] = base + AW'(i) * stride;
    endtask

    task automatic push_words(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                              input int count);
        word_t w;
        for (int i = 0; i < count; i++) begin
            w.data = base + AW'(i) * stride;
            w.idx  = SW'(i);
            w.last = (i == NM - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Assumes the DUT is in FETCH; delays counted in cycles before the done pulse.
    task automatic fetch_compute(input int mem_dly, input int comp_dly);
        repeat (mem_dly) step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        wait_state(S_COMPUTE, 20, "enter_compute");
        repeat (comp_dly) step();
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {mem_start, clr_accum, start_compute, res_valid, res_last, busy,
                     timeout_err, state_out, res_idx}, 64'd0);
        check({name, "_data"}, res_data, 64'd0);
        check({name, "_pass"}, pass_count, 64'd0);
    endtask

    initial begin
        int cyc;

        // Reset state
        #3;
        check_all_zero("reset");
        apply_reset();
        check_all_zero("after_reset");

        // Abort in IDLE is a no-op and blocks start
        abort = 1'b1; start = 1'b1;
        step();
        check("abort_blocks_start", state_out, S_IDLE);
        abort = 1'b0; start = 1'b0;
        step();

        // Single pass
        set_lanes(24'h000100, 24'h1);
        push_words(24'h000100, 24'h1, NM);
        ready_base = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("clr_state", state_out, S_CLEAR);
        check("clr_high", clr_accum, 1);
        step();
        check("clr_low", clr_accum, 0);
        check("mem_start_n2", mem_start, 1);
        fetch_compute(2, 9);
        wait_state(S_DONE, 60, "single_done");
        check("done_not_busy", busy, 0);
        step();
        check("done_to_idle", state_out, S_IDLE);
        check("single_pass_count", pass_count, 1);
        check("single_clr_count", clr_count, 1);
        check("single_words", n_words, NM);
        check("single_q_empty", exp_q.size(), 0);

        // Backpressure
        apply_reset();
        set_lanes(24'h0A0200, 24'h3);
        push_words(24'h0A0200, 24'h3, NM);
        bp_en = 1'b1;
        pulse_start();
        wait_state(S_FETCH, 5, "bp_fetch");
        fetch_compute(1, 2);
        wait_state(S_DONE, 80, "bp_done");
        bp_en = 1'b0;
        check("bp_words", n_words, NM);
        check("bp_q_empty", exp_q.size(), 0);

        // Continuous mode, three passes
        apply_reset();
        set_lanes(24'h123400, 24'h11);
        push_words(24'h123400, 24'h11, NM);
        push_words(24'h123400, 24'h11, NM);
        push_words(24'h123400, 24'h11, NM);
        ready_base = 1'b1;
        cont_mode = 1'b1;
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            wait_state(S_FETCH, 40, "cont_fetch");
            if (p == 2) cont_mode = 1'b0;
            fetch_compute(2, 3);
        end
        wait_state(S_DONE, 60, "cont_done");
        check("cont_pass_count", pass_count, 3);
        check("cont_clr_count", clr_count, 3);
        check("cont_words", n_words, 3 * NM);

        // Watchdog timeout
        apply_reset();
        pulse_start();
        wait_state(S_FETCH, 5, "to_fetch");
        cyc = 0;
        while (state_out !== S_ERROR && cyc < 40) begin
            step();
            cyc++;
        end
        check("to_latency", cyc, TO);
        check("to_state", state_out, S_ERROR);
        check("to_err_set", timeout_err, 1);
        repeat (5) step();
        check("to_err_sticky", timeout_err, 1);
        check("to_still_error", state_out, S_ERROR);
        check("to_mem_start_off", mem_start, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("to_abort_idle", state_out, S_IDLE);
        check("to_err_clear", timeout_err, 0);

        // Abort mid-drain after three transfers
        apply_reset();
        set_lanes(24'h00C000, 24'h5);
        push_words(24'h00C000, 24'h5, 3);
        pulse_start();
        wait_state(S_FETCH, 5, "ab_fetch");
        fetch_compute(1, 1);
        wait_state(S_DRAIN, 10, "ab_drain");
        step();
        ready_base = 1'b1;
        repeat (3) step();
        ready_base = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_valid_drop", res_valid, 0);
        check("ab_idle", state_out, S_IDLE);
        check("ab_pass_count", pass_count, 1);
        check("ab_words", n_words, 3);

        // Reset during COMPUTE, then a clean pass
        apply_reset();
        pulse_start();
        wait_state(S_FETCH, 5, "rc_fetch");
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("rc_compute", state_out, S_COMPUTE);
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("rc_async");
        #3;
        rst_n = 1'b1;
        step();
        set_lanes(24'h055500, 24'h2);
        push_words(24'h055500, 24'h2, NM);
        ready_base = 1'b1;
        pulse_start();
        wait_state(S_FETCH, 5, "rc2_fetch");
        fetch_compute(3, 4);
        wait_state(S_DONE, 60, "rc2_done");
        check("rc2_pass_count", pass_count, 1);
        check("rc2_words", n_words, NM);
        check("rc2_q_empty", exp_q.size(), 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
